btb_update_ctrl: RTL and testbench

//  Sequences every write into the branch target buffer (BTB) write port.
//  - Queues taken-branch resolutions from EX and drains them to the BTB, one write per cycle.
//  - Sweeps all entries invalid after reset and on flush_req (context change, code rewrite).
//  - Sits between the EX-stage branch resolve logic and the BTB. It is the only BTB writer.

---
 rtl/btb_update_ctrl.sv | 173 +++++++++++++++++
 tb/tb_btb_update_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: sole writer of the BTB write port.
//   Buffers taken-branch resolutions from EX in a small FIFO and drains them,
//   one install per cycle. Sweeps every entry invalid after reset and on flush_req.
// Ports:
//   clk, reset (async, active-low)
//   ex_branch/ex_taken/ex_pc/ex_target : branch resolution from EX
//   flush_req                          : single-cycle request to invalidate the BTB
//   btb_wr_en/index/target/valid       : registered BTB write port
//   busy                               : sweep (INIT or FLUSH) in progress
//   q_full                             : update FIFO is full
//   drop_cnt                           : saturating count of updates lost to a full FIFO
module btb_update_ctrl #(
  parameter int unsigned IDX_W   = 8,
  parameter int unsigned Q_DEPTH = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_target,
  input  logic             flush_req,
  output logic             btb_wr_en,
  output logic [IDX_W-1:0] btb_wr_index,
  output logic [31:0]      btb_wr_target,
  output logic             btb_wr_valid,
  output logic             busy,
  output logic             q_full,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned AW = $clog2(Q_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned SW = IDX_W + 1;
  localparam int unsigned EW = IDX_W + 32;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    sweep_idx_q, sweep_idx_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]    mem_q [Q_DEPTH];
  logic [EW-1:0]    mem_d [Q_DEPTH];
  logic             wr_en_q, wr_en_d;
  logic [IDX_W-1:0] wr_index_q, wr_index_d;
  logic [31:0]      wr_target_q, wr_target_d;
  logic             wr_valid_q, wr_valid_d;
  logic             busy_q, busy_d;
  logic             q_full_q, q_full_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [PW-1:0]    count;
  logic             fifo_empty;
  logic             fifo_full;
  logic             sweep_done;
  logic             push_req;
  logic             deq;
  logic [EW-1:0]    head;

  // Only the BTB index bits of the PC are stored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{ex_pc[31:IDX_W+2], ex_pc[1:0]};

  // Next-state, FIFO and write-port logic.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;
    wr_en_d     = 1'b0;
    wr_index_d  = wr_index_q;
    wr_target_d = wr_target_q;
    wr_valid_d  = wr_valid_q;
    drop_cnt_d  = drop_cnt_q;
    deq         = 1'b0;

    count      = PW'(wr_ptr_q - rd_ptr_q);
    fifo_empty = (count == '0);
    fifo_full  = (count == PW'(Q_DEPTH));
    // sweep_idx carries one extra bit so "past the last index" is visible without wrap.
    sweep_done = sweep_idx_q[IDX_W];
    push_req   = ex_branch & ex_taken;
    head       = mem_q[rd_ptr_q[AW-1:0]];

    if (flush_req) begin
      // Discard everything queued, including a same-cycle push.
      state_d     = ST_FLUSH;
      sweep_idx_d = '0;
      rd_ptr_d    = wr_ptr_q;
    end else begin
      if ((state_q != ST_RUN) && !sweep_done) begin
        wr_en_d     = 1'b1;
        wr_valid_d  = 1'b0;
        wr_target_d = '0;
        wr_index_d  = sweep_idx_q[IDX_W-1:0];
        sweep_idx_d = sweep_idx_q + SW'(1);
      end else begin
        // The cycle after the last invalidate already drains, so no bubble.
        state_d = ST_RUN;
        if (!fifo_empty) begin
          deq         = 1'b1;
          wr_en_d     = 1'b1;
          wr_valid_d  = 1'b1;
          wr_index_d  = head[EW-1:32];
          wr_target_d = head[31:0];
          rd_ptr_d    = rd_ptr_q + PW'(1);
        end
      end

      // Fullness is judged after this cycle's dequeue.
      if (push_req) begin
        if (!fifo_full || deq) begin
          mem_d[wr_ptr_q[AW-1:0]] = {ex_pc[IDX_W+1:2], ex_target};
          wr_ptr_d = wr_ptr_q + PW'(1);
        end else if (drop_cnt_q != {CNT_W{1'b1}}) begin
          drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
      end
    end

    busy_d   = (state_d != ST_RUN);
    q_full_d = (PW'(wr_ptr_d - rd_ptr_d) == PW'(Q_DEPTH));
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      sweep_idx_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_index_q  <= '0;
      wr_target_q <= '0;
      wr_valid_q  <= 1'b0;
      busy_q      <= 1'b1;
      q_full_q    <= 1'b0;
      drop_cnt_q  <= '0;
      for (int unsigned i = 0; i < Q_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_en_q     <= wr_en_d;
      wr_index_q  <= wr_index_d;
      wr_target_q <= wr_target_d;
      wr_valid_q  <= wr_valid_d;
      busy_q      <= busy_d;
      q_full_q    <= q_full_d;
      drop_cnt_q  <= drop_cnt_d;
      mem_q       <= mem_d;
    end
  end

  assign btb_wr_en     = wr_en_q;
  assign btb_wr_index  = wr_index_q;
  assign btb_wr_target = wr_target_q;
  assign btb_wr_valid  = wr_valid_q;
  assign busy          = busy_q;
  assign q_full        = q_full_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Testbench for btb_update_ctrl (IDX_W=4, Q_DEPTH=4, CNT_W=8).
module tb_btb_update_ctrl;

  localparam int IDX_W   = 4;
  localparam int Q_DEPTH = 4;
  localparam int CNT_W   = 8;
  localparam int DEPTH   = 16;

  logic        clk;
  logic        reset;
  logic        ex_branch;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        flush_req;
  logic        btb_wr_en;
  logic [3:0]  btb_wr_index;
  logic [31:0] btb_wr_target;
  logic        btb_wr_valid;
  logic        busy;
  logic        q_full;
  logic [7:0]  drop_cnt;

  btb_update_ctrl #(.IDX_W(IDX_W), .Q_DEPTH(Q_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .ex_branch(ex_branch), .ex_taken(ex_taken),
    .ex_pc(ex_pc), .ex_target(ex_target), .flush_req(flush_req),
    .btb_wr_en(btb_wr_en), .btb_wr_index(btb_wr_index), .btb_wr_target(btb_wr_target),
    .btb_wr_valid(btb_wr_valid), .busy(busy), .q_full(q_full), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  logic [47:0] obs;
  assign obs = {btb_wr_en, btb_wr_index, btb_wr_target, btb_wr_valid, busy, q_full, drop_cnt};

  // Reference model: pending updates as a queue, sweep position as a plain integer
  // (-1 means no sweep in progress), expected write-port contents held across idle cycles.
  logic [35:0] mq[$];
  int          sweep_pos;
  int          drops;
  logic        m_en;
  logic [3:0]  m_idx;
  logic [31:0] m_tgt;
  logic        m_valid;
  logic        m_busy;

  localparam logic [47:0] RESET_VEC = {1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00};

  function automatic logic [47:0] exp_vec();
    return {m_en, m_idx, m_tgt, m_valid, m_busy, (mq.size() == Q_DEPTH), 8'(drops)};
  endfunction

  task automatic model_reset();
    mq.delete();
    sweep_pos = 0;
    drops     = 0;
    m_en      = 1'b0;
    m_idx     = '0;
    m_tgt     = '0;
    m_valid   = 1'b0;
    m_busy    = 1'b1;
  endtask

  // Apply one cycle of inputs, advance the model across the edge, settle past the edge.
  task automatic step(input logic br, input logic tk, input logic [31:0] pc,
                      input logic [31:0] tgt, input logic fl);
    logic [35:0] h;
    ex_branch = br;
    ex_taken  = tk;
    ex_pc     = pc;
    ex_target = tgt;
    flush_req = fl;
    @(posedge clk);
    m_en = 1'b0;
    if (fl) begin
      mq.delete();
      sweep_pos = 0;
    end else begin
      if (sweep_pos >= 0 && sweep_pos < DEPTH) begin
        m_en = 1'b1; m_valid = 1'b0; m_tgt = '0; m_idx = 4'(sweep_pos);
        sweep_pos++;
      end else begin
        sweep_pos = -1;
        if (mq.size() > 0) begin
          h = mq.pop_front();
          m_en = 1'b1; m_valid = 1'b1; m_idx = h[35:32]; m_tgt = h[31:0];
        end
      end
      if (br && tk) begin
        if (mq.size() < Q_DEPTH) mq.push_back({pc[5:2], tgt});
        else if (drops < 255) drops++;
      end
    end
    m_busy = (sweep_pos != -1);
    #1;
    ex_branch = 1'b0;
    ex_taken  = 1'b0;
    flush_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs, RESET_VEC);
    end
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checks++;
      if (obs !== exp_vec() || btb_wr_index !== 4'(i) || !btb_wr_en || btb_wr_valid || !busy) begin
        failures++;
        $display("FAIL init_sweep i=%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (obs !== exp_vec() || busy !== 1'b0 || btb_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL init_end got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_single();
    step(1'b1, 1'b1, 32'h40, 32'h100, 1'b0);
    checks++;
    if (obs !== exp_vec() || btb_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL single_push got=%h exp=%h", obs, exp_vec());
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (obs !== exp_vec() || btb_wr_en !== 1'b1 || btb_wr_index !== 4'h0 ||
        btb_wr_target !== 32'h100 || btb_wr_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_install got=%h exp=%h", obs, exp_vec());
    end
    // Not-taken branch must never produce a write.
    step(1'b1, 1'b0, 32'h44, 32'h200, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (obs !== exp_vec() || btb_wr_en !== 1'b0) begin
      failures++;
      $display("FAIL not_taken got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_full_drop();
    logic [35:0] seen[$];
    int d0;
    d0 = int'(drop_cnt);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 32'h100 + 32'(i * 4), 32'h2000 + 32'(i * 16), 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL fill_%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (q_full !== 1'b1 || int'(drop_cnt) != d0 + 1) begin
      failures++;
      $display("FAIL full_drop q_full=%b drop=%0d exp_drop=%0d", q_full, drop_cnt, d0 + 1);
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      if (btb_wr_en && btb_wr_valid) seen.push_back({btb_wr_index, btb_wr_target});
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL drain_%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (seen.size() != 4) begin
      failures++;
      $display("FAIL drain_count got=%0d exp=4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seen[i] !== {4'(i), 32'h2000 + 32'(i * 16)}) begin
          failures++;
          $display("FAIL drain_order_%0d got=%h exp=%h", i, seen[i], {4'(i), 32'h2000 + 32'(i * 16)});
        end
      end
    end
  endtask

  task automatic test_flush_discard();
    int d0;
    int installs;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h88, 32'h3000, 1'b0);
    step(1'b1, 1'b1, 32'h8C, 32'h3004, 1'b0);
    d0 = int'(drop_cnt);
    step(1'b1, 1'b1, 32'h90, 32'h3008, 1'b1);
    checks++;
    if (obs !== exp_vec() || q_full !== 1'b0 || int'(drop_cnt) != d0) begin
      failures++;
      $display("FAIL flush_discard got=%h exp=%h", obs, exp_vec());
    end
    installs = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      if (btb_wr_en && btb_wr_valid) installs++;
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL flush_sweep_%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    checks++;
    if (installs != 0) begin
      failures++;
      $display("FAIL flush_no_install got=%0d exp=0", installs);
    end
  endtask

  task automatic test_flush_restart();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (obs !== exp_vec() || btb_wr_index !== 4'd9) begin
      failures++;
      $display("FAIL restart_at9 got=%h exp=%h", obs, exp_vec());
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checks++;
      if (obs !== exp_vec() || btb_wr_index !== 4'(i) || !btb_wr_en) begin
        failures++;
        $display("FAIL restart_sweep_%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (obs !== exp_vec() || busy !== 1'b0) begin
      failures++;
      $display("FAIL restart_end got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    logic br, tk, fl;
    for (int i = 0; i < 400; i++) begin
      br = 1'($urandom_range(0, 1));
      tk = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 63) == 0);
      step(br, tk, $urandom(), $urandom(), fl);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random_%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 32'h200 + 32'(i * 4), 32'h5000 + 32'(i), 1'b0);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    checks++;
    if (obs !== exp_vec() || btb_wr_valid !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_drain got=%h exp=%h", obs, exp_vec());
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== RESET_VEC) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obs, RESET_VEC);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL post_reset_%0d got=%h exp=%h", i, obs, exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    for (int it = 0; it < 26; it++) begin
      step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
        step(1'b1, 1'b1, $urandom(), $urandom(), 1'b0);
        checks++;
        if (obs !== exp_vec()) begin
          failures++;
          $display("FAIL sat_%0d_%0d got=%h exp=%h", it, i, obs, exp_vec());
        end
      end
    end
    checks++;
    if (drop_cnt !== 8'd255) begin
      failures++;
      $display("FAIL saturation got=%0d exp=255", drop_cnt);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    ex_branch = 1'b0;
    ex_taken  = 1'b0;
    ex_pc     = '0;
    ex_target = '0;
    flush_req = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_full_drop();
    test_flush_discard();
    test_flush_restart();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
